uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 9: width of each requester's data word and of the data driven to the UART transmitter.
REQ-002 Parameter TIMEOUT_CYCLES, default 500_000: watchdog limit in Clk_In cycles (used only when UART_ARB_TIMEOUT_EN is defined).
REQ-003 Clk_In  input  1  single system clock; all state updates on its rising edge.
REQ-004 Reset_In  input  1  synchronous, active-high reset.
REQ-005 Req_In  input  4  per-requester transmit request, level, bit i = requester i.
REQ-006 Req_Data_In  input  4*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 Grant_Out  output  4  one-hot grant, held from arbitration until frame completion or abort.
REQ-008 Done_Out  output  4  one-cycle pulse on bit i when requester i's frame completes.
REQ-009 Error_Out  output  1  one-cycle pulse on watchdog abort.
REQ-010 UART_Start_Out  output  1  one-cycle start pulse to the shared UART transmitter.
REQ-011 UART_Data_Out  output  DATA_WIDTH  data word for the transmitter, stable from grant until frame end.
REQ-012 UART_Busy_In  input  1  transmitter busy level.
REQ-013 UART_Done_In  input  1  transmitter one-cycle frame-complete pulse.

Function
REQ-014 The block SHALL implement FSM states IDLE, LAUNCH, WAIT_DONE; all outputs registered.
REQ-015 IDLE: if Req_In != 0, it SHALL select the winner by round-robin search starting at pointer Ptr (2 bits), latch its data into UART_Data_Out, set Grant_Out one-hot, and go to LAUNCH (grant visible 1 cycle after request sampled).
REQ-016 LAUNCH: if UART_Busy_In = 0, it SHALL pulse UART_Start_Out for exactly one cycle and go to WAIT_DONE; if UART_Busy_In = 1, it SHALL stay in LAUNCH with grant and data held.
REQ-017 WAIT_DONE: on UART_Done_In = 1 it SHALL pulse Done_Out[winner] next cycle, clear Grant_Out the same cycle, set Ptr = (winner+1) mod 4, and return to IDLE.
REQ-018 Minimum spacing between two UART_Start_Out pulses SHALL be 3 cycles after UART_Done_In (IDLE, LAUNCH, start).
REQ-019 UART_Done_In outside WAIT_DONE SHALL be ignored.
REQ-020 Deassertion of Req_In[winner] after grant SHALL NOT abort the frame; Done_Out still pulses.
REQ-021 Req_In changes and Req_Data_In changes after grant SHALL NOT affect UART_Data_Out or the winner.
REQ-022 Simultaneous requests: with Ptr = p, the lowest index i in order p, p+1, ... (mod 4) with Req_In[i] = 1 SHALL win; Ptr SHALL advance only on completion or abort.
REQ-023 At most one Grant_Out bit and at most one Done_Out bit SHALL be high in any cycle.

Reset
REQ-024 On Reset_In = 1 at a clock edge: state IDLE, Ptr = 0, Grant_Out = 0, Done_Out = 0, Error_Out = 0, UART_Start_Out = 0, UART_Data_Out = 0, watchdog counter = 0.
REQ-025 Reset in LAUNCH or WAIT_DONE SHALL abandon the frame with no Done_Out or Error_Out pulse.
REQ-026 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-027 Macro UART_ARB_TIMEOUT_EN defined: a counter SHALL clear on LAUNCH entry and count each cycle in LAUNCH and WAIT_DONE; on reaching TIMEOUT_CYCLES-1 without UART_Done_In it SHALL pulse Error_Out, suppress Done_Out, clear Grant_Out, advance Ptr past the winner and return to IDLE; UART_Done_In in that same cycle SHALL take priority (normal completion).
REQ-028 Macro undefined: no counter SHALL be built, Error_Out SHALL be tied 0, and the FSM SHALL wait indefinitely.

Verification
REQ-029 Reset, Req_In=4'b0001, data0=9'h0A5, Busy=0 -> Grant_Out=0001 at +1, UART_Start_Out pulse at +2 with UART_Data_Out=9'h0A5; Done_In pulse -> Done_Out=0001 next cycle, Ptr=1.
REQ-030 Req_In=4'b1111 held, Done_In 10 cycles after each start -> grant order 0,1,2,3,0; exactly one Done_Out bit per frame.
REQ-031 Grant to requester 2 with UART_Busy_In=1 for 20 cycles -> no start pulse for 20 cycles, start on first cycle Busy=0, data unchanged.
REQ-032 Reset_In asserted 5 cycles into WAIT_DONE -> all outputs 0 next cycle, no Done_Out/Error_Out; then Req_In=4'b0100 -> requester 2 granted (Ptr=0 search).
REQ-033 With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100, no Done_In -> Error_Out single pulse 100 cycles after LAUNCH entry, Grant cleared, Ptr advanced; without macro, Grant held past 1000 cycles.
REQ-034 Done_In pulsed while IDLE and Req_In=0 -> no output change.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Four-requester round-robin arbiter feeding one shared UART transmitter.
// Optional watchdog abort is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH     = 9,
  parameter int TIMEOUT_CYCLES = 500_000
) (
  input  logic                    Clk_In,
  input  logic                    Reset_In,
  input  logic [3:0]              Req_In,
  input  logic [4*DATA_WIDTH-1:0] Req_Data_In,
  output logic [3:0]              Grant_Out,
  output logic [3:0]              Done_Out,
  output logic                    Error_Out,
  output logic                    UART_Start_Out,
  output logic [DATA_WIDTH-1:0]   UART_Data_Out,
  input  logic                    UART_Busy_In,
  input  logic                    UART_Done_In
);

  // state     | meaning
  // IDLE      | no frame owned; arbitrate when any request is present
  // LAUNCH    | winner granted, waiting for the transmitter to be free
  // WAIT_DONE | start issued, waiting for the frame-complete pulse
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              ptr_q, ptr_d;
  logic [1:0]              winner_q, winner_d;
  logic [3:0]              grant_q, grant_d;
  logic [3:0]              done_q, done_d;
  logic                    start_q, start_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [1:0]              pick_idx;
  logic                    tmo_abort;

  // Later offsets are overwritten by earlier ones, so the first hit from ptr_q wins.
  always_comb begin
    pick_idx = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (Req_In[ptr_q + 2'(k)]) begin
        pick_idx = ptr_q + 2'(k);
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             error_q;
  logic             tmo_hit;

  assign tmo_hit   = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  // A frame-complete pulse in the same cycle wins over the watchdog.
  assign tmo_abort = tmo_hit && !((state_q == WAIT_DONE) && UART_Done_In);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (state_q == IDLE) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      error_q <= tmo_abort;
    end
  end

  assign Error_Out = error_q;
`else
  assign tmo_abort = 1'b0;
  assign Error_Out = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    grant_d  = grant_q;
    data_d   = data_q;
    done_d   = 4'b0000;
    start_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|Req_In) begin
          winner_d = pick_idx;
          grant_d  = 4'(1) << pick_idx;
          data_d   = Req_Data_In[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        if (tmo_abort) begin
          grant_d = 4'b0000;
          ptr_d   = winner_q + 2'd1;
          state_d = IDLE;
        end else if (!UART_Busy_In) begin
          start_d = 1'b1;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (UART_Done_In) begin
          done_d  = 4'(1) << winner_q;
          grant_d = 4'b0000;
          ptr_d   = winner_q + 2'd1;
          state_d = IDLE;
        end else if (tmo_abort) begin
          grant_d = 4'b0000;
          ptr_d   = winner_q + 2'd1;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = 4'b0000;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd0;
      winner_q <= 2'd0;
      grant_q  <= 4'b0000;
      done_q   <= 4'b0000;
      start_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      start_q  <= start_d;
      data_q   <= data_d;
    end
  end

  assign Grant_Out      = grant_q;
  assign Done_Out       = done_q;
  assign UART_Start_Out = start_q;
  assign UART_Data_Out  = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: arbitration order, busy stall, reset abort,
// idle done-ignore and watchdog behaviour for whichever build is compiled.
module tb_uart_tx_arbiter;

  localparam int DW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [4*DW-1:0] req_data;
  logic [3:0]    grant;
  logic [3:0]    done;
  logic          err;
  logic          start;
  logic [DW-1:0] udata;
  logic          busy;
  logic          udone;

  int tests  = 0;
  int failed = 0;

  uart_tx_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(100)) dut (
    .Clk_In         (clk),
    .Reset_In       (rst),
    .Req_In         (req),
    .Req_Data_In    (req_data),
    .Grant_Out      (grant),
    .Done_Out       (done),
    .Error_Out      (err),
    .UART_Start_Out (start),
    .UART_Data_Out  (udata),
    .UART_Busy_In   (busy),
    .UART_Done_In   (udone)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int idx, input logic [DW-1:0] val);
    req_data[idx*DW +: DW] = val;
  endtask

  initial begin
    logic [DW-1:0] dv [4];
    int            exp_w;
    int            extra;

    rst = 1'b1; req = 4'b0000; req_data = '0; busy = 1'b0; udone = 1'b0;
    dv[0] = 9'h100; dv[1] = 9'h111; dv[2] = 9'h122; dv[3] = 9'h133;
    step();
    step();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_done",  32'(done),  32'h0);
    chk("rst_err",   32'(err),   32'h0);
    chk("rst_start", 32'(start), 32'h0);
    chk("rst_data",  32'(udata), 32'h0);

    // Single request from requester 0
    rst = 1'b0;
    set_data(0, 9'h0A5);
    req = 4'b0001;
    step();
    chk("t1_grant",   32'(grant), 32'h1);
    chk("t1_nostart", 32'(start), 32'h0);
    step();
    chk("t1_start", 32'(start), 32'h1);
    chk("t1_data",  32'(udata), 32'h0A5);
    req = 4'b0000;
    step();
    chk("t1_start_pulse", 32'(start), 32'h0);
    chk("t1_grant_held",  32'(grant), 32'h1);
    step();
    step();
    udone = 1'b1;
    step();
    udone = 1'b0;
    chk("t1_done",     32'(done),  32'h1);
    chk("t1_grant_clr", 32'(grant), 32'h0);
    step();
    chk("t1_done_pulse", 32'(done), 32'h0);

    // Done pulse while idle must be ignored
    udone = 1'b1;
    step();
    udone = 1'b0;
    chk("idle_done_grant", 32'(grant), 32'h0);
    chk("idle_done_done",  32'(done),  32'h0);
    chk("idle_done_start", 32'(start), 32'h0);
    chk("idle_done_data",  32'(udata), 32'h0A5);

    // All four requesting; pointer is 1 after the first frame
    for (int i = 0; i < 4; i++) set_data(i, dv[i]);
    req = 4'b1111;
    exp_w = 1;
    for (int f = 0; f < 5; f++) begin
      step();
      chk("rr_grant", 32'(grant), 32'(4'(1) << exp_w));
      chk("rr_data",  32'(udata), 32'(dv[exp_w]));
      step();
      chk("rr_start", 32'(start), 32'h1);
      extra = 0;
      for (int c = 0; c < 9; c++) begin
        step();
        if (start !== 1'b0 || done !== 4'b0000) extra++;
      end
      chk("rr_quiet", 32'(extra), 32'h0);
      udone = 1'b1;
      step();
      udone = 1'b0;
      chk("rr_done",      32'(done),  32'(4'(1) << exp_w));
      chk("rr_grant_clr", 32'(grant), 32'h0);
      exp_w = (exp_w + 1) % 4;
    end
    req = 4'b0000;

    // Requester 2 granted while the transmitter stays busy
    req  = 4'b0100;
    busy = 1'b1;
    step();
    chk("busy_grant", 32'(grant), 32'h4);
    chk("busy_data",  32'(udata), 32'h122);
    set_data(2, 9'h0FF);
    req = 4'b0000;
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (start !== 1'b0 || udata !== 9'h122 || grant !== 4'b0100) extra++;
    end
    chk("busy_stall", 32'(extra), 32'h0);
    busy = 1'b0;
    step();
    chk("busy_start", 32'(start), 32'h1);
    chk("busy_data_held", 32'(udata), 32'h122);

    // Reset five cycles into WAIT_DONE, colliding with a done pulse
    step();
    step();
    step();
    step();
    rst   = 1'b1;
    udone = 1'b1;
    step();
    chk("rab_grant", 32'(grant), 32'h0);
    chk("rab_done",  32'(done),  32'h0);
    chk("rab_err",   32'(err),   32'h0);
    chk("rab_start", 32'(start), 32'h0);
    chk("rab_data",  32'(udata), 32'h0);
    rst   = 1'b0;
    udone = 1'b0;
    set_data(2, 9'h055);
    req = 4'b0100;
    step();
    chk("post_rst_grant", 32'(grant), 32'h4);
    chk("post_rst_data",  32'(udata), 32'h055);

`ifdef UART_ARB_TIMEOUT_EN
    for (int c = 0; c < 99; c++) step();
    chk("tmo_pre_err",   32'(err),   32'h0);
    chk("tmo_pre_grant", 32'(grant), 32'h4);
    step();
    chk("tmo_err",   32'(err),   32'h1);
    chk("tmo_grant", 32'(grant), 32'h0);
    chk("tmo_done",  32'(done),  32'h0);
    req = 4'b1111;
    step();
    chk("tmo_err_pulse", 32'(err), 32'h0);
`else
    for (int c = 0; c < 1000; c++) step();
    chk("hold_grant", 32'(grant), 32'h4);
    chk("hold_err",   32'(err),   32'h0);
    udone = 1'b1;
    step();
    udone = 1'b0;
    chk("hold_done", 32'(done), 32'h4);
    req = 4'b1111;
    step();
`endif
    chk("ptr_adv_grant", 32'(grant), 32'h8);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
